// File: rtl/pc_stack_unit_if.sv
// Control/status bundle between the controller and the PC/return-stack unit.
// Latency: none, plain wires.
// Backpressure: none, every control strobe is acted on in the cycle it is sampled.
interface pc_stack_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4,
    parameter int SP_W   = $clog2(DEPTH + 1)
);
    // controller -> unit strobes
    logic              pc_inc;
    logic              pc_load;
    logic              pc_enable;
    logic              call;
    logic              ret;
    logic              halt;
    // unit -> controller / debug status
    logic [ADDR_W-1:0] pc_out;
    logic [SP_W-1:0]   sp_out;
    logic              stack_full;
    logic              stack_empty;
    logic              err;

    modport master (
        output pc_inc, pc_load, pc_enable, call, ret, halt,
        input  pc_out, sp_out, stack_full, stack_empty, err
    );

    modport slave (
        input  pc_inc, pc_load, pc_enable, call, ret, halt,
        output pc_out, sp_out, stack_full, stack_empty, err
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack (CALL/RET), jump-load and bus drive.
// Latency: state updates visible one cycle after the sampling edge; bus drive is combinational.
// Backpressure: none; overflow/underflow are dropped and recorded in the sticky err flag.
module pc_stack_unit #(
    parameter int ADDR_W = 8,
    parameter int BUS_W  = 8,
    parameter int DEPTH  = 4,
    parameter int SP_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    pc_stack_unit_if.slave    ctl,
    inout  wire [BUS_W-1:0]   bus
);
    // index width for the stack array itself (sp can reach DEPTH, an index never does)
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_dat;

    logic [ADDR_W-1:0] pc_plus1;
    logic [SP_W-1:0]   sp_m1;
    logic [ADDR_W-1:0] bus_val;
    logic [BUS_W-1:0]  pc_bus;

    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign sp_m1    = sp_q - SP_W'(1);

    // Width adaptation between PC and bus in both directions
    generate
        if (BUS_W >= ADDR_W) begin : g_wide_bus
            assign bus_val = bus[ADDR_W-1:0];
            assign pc_bus  = BUS_W'(pc_q);
        end else begin : g_narrow_bus
            assign bus_val = ADDR_W'(bus);
            assign pc_bus  = pc_q[BUS_W-1:0];
        end
    endgenerate

    // Bus is released unless the controller asks for the PC; halt does not affect this
    assign bus = ctl.pc_enable ? pc_bus : {BUS_W{1'bz}};

    // Next-state selection, one action per edge: halt > ret > call > pc_load > pc_inc
    always_comb begin
        pc_d   = pc_q;
        sp_d   = sp_q;
        err_d  = err_q;
        wr_en  = 1'b0;
        wr_idx = sp_q[IDX_W-1:0];
        wr_dat = pc_plus1;
        if (!ctl.halt) begin
            if (ctl.ret) begin
                if (sp_q != '0) begin
                    pc_d = stack_q[sp_m1[IDX_W-1:0]];
                    sp_d = sp_m1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (ctl.call) begin
                if (sp_q != SP_W'(DEPTH)) begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + SP_W'(1);
                    pc_d  = bus_val;
                end else begin
                    err_d = 1'b1;
                end
            end else if (ctl.pc_load) begin
                pc_d = bus_val;
            end else if (ctl.pc_inc) begin
                pc_d = pc_plus1;
            end
        end
    end

    // PC, stack pointer and sticky error register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-address storage; a pop leaves the old entry in place
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (wr_en) begin
            stack_q[wr_idx] <= wr_dat;
        end
    end

    // Status taken straight from the registered state
    assign ctl.pc_out      = pc_q;
    assign ctl.sp_out      = sp_q;
    assign ctl.stack_full  = (sp_q == SP_W'(DEPTH));
    assign ctl.stack_empty = (sp_q == '0);
    assign ctl.err         = err_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: default 8/8/4 instance plus a 10-bit-PC / 8-bit-bus instance.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Each feature task does its own comparisons and steps the shared counters.
module tb_pc_stack_unit;
    logic clk;
    logic rst;
    int   chk;
    int   pass;

    pc_stack_unit_if #(.ADDR_W(8),  .DEPTH(4)) ia ();
    pc_stack_unit_if #(.ADDR_W(10), .DEPTH(4)) ib ();

    wire  [7:0] bus_a;
    wire  [7:0] bus_b;
    logic [7:0] drv_a, drv_b;
    logic       drv_a_en, drv_b_en;

    assign bus_a = drv_a_en ? drv_a : 8'hzz;
    assign bus_b = drv_b_en ? drv_b : 8'hzz;

    pc_stack_unit #(.ADDR_W(8), .BUS_W(8), .DEPTH(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .ctl (ia),
        .bus (bus_a)
    );

    pc_stack_unit #(.ADDR_W(10), .BUS_W(8), .DEPTH(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .ctl (ib),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ia.pc_inc = 0; ia.pc_load = 0; ia.pc_enable = 0; ia.call = 0; ia.ret = 0; ia.halt = 0;
        ib.pc_inc = 0; ib.pc_load = 0; ib.pc_enable = 0; ib.call = 0; ib.ret = 0; ib.halt = 0;
        drv_a_en = 0; drv_b_en = 0; drv_a = 8'h00; drv_b = 8'h00;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic ld_a(input logic [7:0] v);
        drv_a = v; drv_a_en = 1; ia.pc_load = 1;
        cyc();
        ia.pc_load = 0; drv_a_en = 0;
    endtask

    task automatic call_a(input logic [7:0] v);
        drv_a = v; drv_a_en = 1; ia.call = 1;
        cyc();
        ia.call = 0; drv_a_en = 0;
    endtask

    task automatic ret_a();
        ia.ret = 1;
        cyc();
        ia.ret = 0;
    endtask

    task automatic ld_b(input logic [7:0] v);
        drv_b = v; drv_b_en = 1; ib.pc_load = 1;
        cyc();
        ib.pc_load = 0; drv_b_en = 0;
    endtask

    task automatic test_reset();
        // reset asserted while a call is requested: reset must win
        drv_a = 8'h33; drv_a_en = 1; ia.call = 1;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0; ia.call = 0; drv_a_en = 0;
        chk++; if (ia.pc_out !== 8'h00) $display("FAIL rst_pc: got %h exp 00", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd0) $display("FAIL rst_sp: got %0d exp 0", ia.sp_out); else pass++;
        chk++; if (ia.stack_empty !== 1'b1) $display("FAIL rst_empty: got %b exp 1", ia.stack_empty); else pass++;
        chk++; if (ia.stack_full !== 1'b0) $display("FAIL rst_full: got %b exp 0", ia.stack_full); else pass++;
        chk++; if (ia.err !== 1'b0) $display("FAIL rst_err: got %b exp 0", ia.err); else pass++;
    endtask

    task automatic test_inc();
        logic [7:0] exp_pc [3];
        exp_pc[0] = 8'h01; exp_pc[1] = 8'h02; exp_pc[2] = 8'h03;
        ia.pc_inc = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk++; if (ia.pc_out !== exp_pc[i]) $display("FAIL inc%0d: got %h exp %h", i, ia.pc_out, exp_pc[i]); else pass++;
        end
        ia.pc_inc = 0;
        ld_a(8'hFF);
        chk++; if (ia.pc_out !== 8'hFF) $display("FAIL load_ff: got %h exp ff", ia.pc_out); else pass++;
        ia.pc_inc = 1;
        cyc();
        ia.pc_inc = 0;
        chk++; if (ia.pc_out !== 8'h00) $display("FAIL inc_wrap: got %h exp 00", ia.pc_out); else pass++;
    endtask

    task automatic test_bus_drive();
        ld_a(8'h3C);
        ia.pc_enable = 1;
        #1;
        chk++; if (bus_a !== 8'h3C) $display("FAIL bus_drive: got %h exp 3c", bus_a); else pass++;
        ia.pc_enable = 0;
        drv_a = 8'h5A; drv_a_en = 1;
        #1;
        chk++; if (bus_a !== 8'h5A) $display("FAIL bus_release: got %h exp 5a", bus_a); else pass++;
        drv_a_en = 0;
        // halt does not stop the bus drive
        ia.halt = 1; ia.pc_enable = 1;
        #1;
        chk++; if (bus_a !== 8'h3C) $display("FAIL bus_halt: got %h exp 3c", bus_a); else pass++;
        ia.halt = 0; ia.pc_enable = 0;
    endtask

    task automatic test_call_ret();
        do_rst();
        ld_a(8'h05);
        call_a(8'h40);
        chk++; if (ia.pc_out !== 8'h40) $display("FAIL call1_pc: got %h exp 40", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd1) $display("FAIL call1_sp: got %0d exp 1", ia.sp_out); else pass++;
        call_a(8'h80);
        chk++; if (ia.pc_out !== 8'h80) $display("FAIL call2_pc: got %h exp 80", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd2) $display("FAIL call2_sp: got %0d exp 2", ia.sp_out); else pass++;
        ret_a();
        chk++; if (ia.pc_out !== 8'h41) $display("FAIL ret1_pc: got %h exp 41", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd1) $display("FAIL ret1_sp: got %0d exp 1", ia.sp_out); else pass++;
        ret_a();
        chk++; if (ia.pc_out !== 8'h06) $display("FAIL ret2_pc: got %h exp 06", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd0) $display("FAIL ret2_sp: got %0d exp 0", ia.sp_out); else pass++;
        chk++; if (ia.stack_empty !== 1'b1) $display("FAIL ret2_empty: got %b exp 1", ia.stack_empty); else pass++;
        chk++; if (ia.err !== 1'b0) $display("FAIL ret2_err: got %b exp 0", ia.err); else pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] tgt [4];
        logic [7:0] ra  [4];
        tgt[0] = 8'h10; tgt[1] = 8'h20; tgt[2] = 8'h30; tgt[3] = 8'h40;
        // return addresses expected back, innermost first
        ra[0] = 8'h31; ra[1] = 8'h21; ra[2] = 8'h11; ra[3] = 8'h01;
        do_rst();
        for (int i = 0; i < 4; i++) call_a(tgt[i]);
        chk++; if (ia.stack_full !== 1'b1) $display("FAIL ovf_full: got %b exp 1", ia.stack_full); else pass++;
        chk++; if (ia.sp_out !== 3'd4) $display("FAIL ovf_sp4: got %0d exp 4", ia.sp_out); else pass++;
        chk++; if (ia.err !== 1'b0) $display("FAIL ovf_err_pre: got %b exp 0", ia.err); else pass++;
        call_a(8'h22);
        chk++; if (ia.pc_out !== 8'h40) $display("FAIL ovf_pc: got %h exp 40", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd4) $display("FAIL ovf_sp: got %0d exp 4", ia.sp_out); else pass++;
        chk++; if (ia.err !== 1'b1) $display("FAIL ovf_err: got %b exp 1", ia.err); else pass++;
        for (int i = 0; i < 4; i++) begin
            ret_a();
            chk++; if (ia.pc_out !== ra[i]) $display("FAIL ovf_ret%0d: got %h exp %h", i, ia.pc_out, ra[i]); else pass++;
        end
        chk++; if (ia.sp_out !== 3'd0) $display("FAIL ovf_sp_end: got %0d exp 0", ia.sp_out); else pass++;
        chk++; if (ia.err !== 1'b1) $display("FAIL ovf_err_sticky: got %b exp 1", ia.err); else pass++;
    endtask

    task automatic test_underflow();
        do_rst();
        ret_a();
        chk++; if (ia.pc_out !== 8'h00) $display("FAIL unf_pc: got %h exp 00", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd0) $display("FAIL unf_sp: got %0d exp 0", ia.sp_out); else pass++;
        chk++; if (ia.err !== 1'b1) $display("FAIL unf_err: got %b exp 1", ia.err); else pass++;
        do_rst();
        chk++; if (ia.err !== 1'b0) $display("FAIL unf_err_clr: got %b exp 0", ia.err); else pass++;
    endtask

    task automatic test_priority();
        do_rst();
        ld_a(8'h55);
        // halt beats inc and call
        ia.halt = 1; ia.pc_inc = 1;
        call_a(8'h77);
        ia.halt = 0; ia.pc_inc = 0;
        chk++; if (ia.pc_out !== 8'h55) $display("FAIL halt_pc: got %h exp 55", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd0) $display("FAIL halt_sp: got %0d exp 0", ia.sp_out); else pass++;
        // ret beats call
        call_a(8'h60);
        chk++; if (ia.sp_out !== 3'd1) $display("FAIL rc_pre_sp: got %0d exp 1", ia.sp_out); else pass++;
        ia.ret = 1;
        call_a(8'h70);
        ia.ret = 0;
        chk++; if (ia.pc_out !== 8'h56) $display("FAIL rc_pc: got %h exp 56", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd0) $display("FAIL rc_sp: got %0d exp 0", ia.sp_out); else pass++;
        chk++; if (ia.err !== 1'b0) $display("FAIL rc_err: got %b exp 0", ia.err); else pass++;
        // load beats inc
        ia.pc_inc = 1;
        ld_a(8'h10);
        ia.pc_inc = 0;
        chk++; if (ia.pc_out !== 8'h10) $display("FAIL ld_inc_pc: got %h exp 10", ia.pc_out); else pass++;
        // reset beats call
        call_a(8'h20);
        drv_a = 8'h44; drv_a_en = 1; ia.call = 1; rst = 1;
        cyc();
        rst = 0; ia.call = 0; drv_a_en = 0;
        chk++; if (ia.pc_out !== 8'h00) $display("FAIL rst_call_pc: got %h exp 00", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd0) $display("FAIL rst_call_sp: got %0d exp 0", ia.sp_out); else pass++;
    endtask

    task automatic test_enable_load();
        do_rst();
        ld_a(8'h2A);
        ia.pc_enable = 1; ia.pc_load = 1;
        cyc();
        ia.pc_load = 0;
        chk++; if (ia.pc_out !== 8'h2A) $display("FAIL en_load_pc: got %h exp 2a", ia.pc_out); else pass++;
        ia.call = 1;
        cyc();
        ia.call = 0; ia.pc_enable = 0;
        chk++; if (ia.pc_out !== 8'h2A) $display("FAIL en_call_pc: got %h exp 2a", ia.pc_out); else pass++;
        chk++; if (ia.sp_out !== 3'd1) $display("FAIL en_call_sp: got %0d exp 1", ia.sp_out); else pass++;
        ret_a();
        chk++; if (ia.pc_out !== 8'h2B) $display("FAIL en_call_ret: got %h exp 2b", ia.pc_out); else pass++;
    endtask

    task automatic test_param();
        do_rst();
        ld_b(8'hAB);
        chk++; if (ib.pc_out !== 10'h0AB) $display("FAIL p_load: got %h exp 0ab", ib.pc_out); else pass++;
        ld_b(8'hFF);
        ib.pc_inc = 1;
        repeat (768) cyc();
        ib.pc_inc = 0;
        chk++; if (ib.pc_out !== 10'h3FF) $display("FAIL p_3ff: got %h exp 3ff", ib.pc_out); else pass++;
        ib.pc_inc = 1;
        cyc();
        ib.pc_inc = 0;
        chk++; if (ib.pc_out !== 10'h000) $display("FAIL p_wrap: got %h exp 000", ib.pc_out); else pass++;
        ld_b(8'hC3);
        ib.pc_inc = 1;
        repeat (256) cyc();
        ib.pc_inc = 0;
        chk++; if (ib.pc_out !== 10'h1C3) $display("FAIL p_1c3: got %h exp 1c3", ib.pc_out); else pass++;
        ib.pc_enable = 1;
        #1;
        chk++; if (bus_b !== 8'hC3) $display("FAIL p_bus: got %h exp c3", bus_b); else pass++;
        ib.pc_enable = 0;
    endtask

    initial begin
        chk  = 0;
        pass = 0;
        rst  = 1'b1;
        idle_all();
        test_reset();
        test_inc();
        test_bus_drive();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_priority();
        test_enable_load();
        test_param();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
